// File: rtl/cfg_master_if.sv
// Command/response bus between a test sequencer and cfg_master.
`timescale 1ns/1ps
interface cfg_master_if;
    logic [23:0] cmd_data;
    logic        snd_frm;
    logic [15:0] resp;
    logic        rsp_rdy;

    modport master (
        output cmd_data, snd_frm,
        input  resp, rsp_rdy
    );

    modport slave (
        input  cmd_data, snd_frm,
        output resp, rsp_rdy
    );
endinterface

// File: rtl/cfg_master.sv
// Config-UART master: sends 3-byte 8N1 command frames, collects 2-byte responses.
// Optional CFG_RX_SYNC_EN adds a two-flop synchronizer on RX_C.
`timescale 1ns/1ps
module cfg_master #(
    parameter int BIT_CLKS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    cfg_master_if.slave  bus,
    output logic         TX_C,
    input  logic         RX_C
);
    localparam int CW = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF = CW'(BIT_CLKS / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    tx_state_t     tx_st, tx_nx;
    logic [CW-1:0] tx_cnt, tx_cnt_nx;
    logic [2:0]    tx_bit, tx_bit_nx;
    logic [1:0]    tx_byte, tx_byte_nx;
    logic [23:0]   frm, frm_nx;
    logic [7:0]    cur;
    logic          tx_wrap;
    logic          accept;

    assign accept  = (tx_st == IDLE) && bus.snd_frm;
    assign tx_wrap = (tx_cnt == LAST);

    always_comb begin
        case (tx_byte)
            2'd0:    cur = frm[23:16];
            2'd1:    cur = frm[15:8];
            default: cur = frm[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st   <= IDLE;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
            frm     <= '0;
        end else begin
            tx_st   <= tx_nx;
            tx_cnt  <= tx_cnt_nx;
            tx_bit  <= tx_bit_nx;
            tx_byte <= tx_byte_nx;
            frm     <= frm_nx;
        end
    end

    always_comb begin
        tx_nx      = tx_st;
        tx_cnt_nx  = tx_cnt;
        tx_bit_nx  = tx_bit;
        tx_byte_nx = tx_byte;
        frm_nx     = frm;
        if (tx_st != IDLE)
            tx_cnt_nx = tx_wrap ? '0 : tx_cnt + CW'(1);
        unique case (tx_st)
            IDLE: begin
                if (bus.snd_frm) begin
                    frm_nx     = bus.cmd_data;
                    tx_nx      = START;
                    tx_cnt_nx  = '0;
                    tx_byte_nx = 2'd0;
                end
            end
            START: begin
                if (tx_wrap) begin
                    tx_nx     = DATA;
                    tx_bit_nx = 3'd0;
                end
            end
            DATA: begin
                if (tx_wrap) begin
                    tx_bit_nx = tx_bit + 3'd1;
                    if (tx_bit == 3'd7)
                        tx_nx = STOP;
                end
            end
            STOP: begin
                if (tx_wrap) begin
                    if (tx_byte == 2'd2) begin
                        tx_nx = IDLE;
                    end else begin
                        tx_nx      = START;
                        tx_byte_nx = tx_byte + 2'd1;
                    end
                end
            end
            default: tx_nx = IDLE;
        endcase
    end

    // Line is decoded from registered state so reset forces it high at once.
    always_comb begin
        TX_C = 1'b1;
        if (tx_st == START)
            TX_C = 1'b0;
        else if (tx_st == DATA)
            TX_C = cur[tx_bit];
    end

    logic rx_in;
`ifdef CFG_RX_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync <= 2'b11;
        else
            sync <= {sync[0], RX_C};
    end
    assign rx_in = sync[1];
`else
    assign rx_in = RX_C;
`endif

    rx_state_t     rx_st, rx_nx;
    logic [CW-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]    rx_bit, rx_bit_nx;
    logic [7:0]    rx_sh, rx_sh_nx;
    logic [7:0]    hi, hi_nx;
    logic          have_hi, have_hi_nx;
    logic [15:0]   resp_q, resp_nx;
    logic          rdy_q, rdy_nx;
    logic          rx_wrap;

    assign rx_wrap     = (rx_cnt == LAST);
    assign bus.resp    = resp_q;
    assign bus.rsp_rdy = rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st   <= R_IDLE;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_sh   <= '0;
            hi      <= '0;
            have_hi <= 1'b0;
            resp_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rx_st   <= rx_nx;
            rx_cnt  <= rx_cnt_nx;
            rx_bit  <= rx_bit_nx;
            rx_sh   <= rx_sh_nx;
            hi      <= hi_nx;
            have_hi <= have_hi_nx;
            resp_q  <= resp_nx;
            rdy_q   <= rdy_nx;
        end
    end

    always_comb begin
        rx_nx      = rx_st;
        rx_cnt_nx  = rx_cnt;
        rx_bit_nx  = rx_bit;
        rx_sh_nx   = rx_sh;
        hi_nx      = hi;
        have_hi_nx = have_hi;
        resp_nx    = resp_q;
        rdy_nx     = 1'b0;
        unique case (rx_st)
            R_IDLE: begin
                if (!rx_in) begin
                    rx_nx     = R_START;
                    rx_cnt_nx = '0;
                end
            end
            R_START: begin
                // Half-bit recheck; later samples then land at bit centres.
                if (rx_cnt == HALF) begin
                    rx_cnt_nx = '0;
                    rx_bit_nx = 3'd0;
                    rx_nx     = rx_in ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_nx = rx_cnt + CW'(1);
                end
            end
            R_DATA: begin
                if (rx_wrap) begin
                    rx_cnt_nx = '0;
                    rx_sh_nx  = {rx_in, rx_sh[7:1]};
                    rx_bit_nx = rx_bit + 3'd1;
                    if (rx_bit == 3'd7)
                        rx_nx = R_STOP;
                end else begin
                    rx_cnt_nx = rx_cnt + CW'(1);
                end
            end
            R_STOP: begin
                if (rx_wrap) begin
                    rx_cnt_nx = '0;
                    rx_nx     = R_IDLE;
                    if (!rx_in) begin
                        have_hi_nx = 1'b0;
                    end else if (!have_hi) begin
                        hi_nx      = rx_sh;
                        have_hi_nx = 1'b1;
                    end else begin
                        resp_nx    = {hi, rx_sh};
                        rdy_nx     = 1'b1;
                        have_hi_nx = 1'b0;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + CW'(1);
                end
            end
            default: rx_nx = R_IDLE;
        endcase
        if (accept)
            have_hi_nx = 1'b0;
    end
endmodule

// File: tb/tb_cfg_master.sv
// Directed bench for cfg_master: TX frame timing, RX word assembly, errors, reset.
`timescale 1ns/1ps
module tb_cfg_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    logic rx = 1'b1;

    cfg_master_if bus();

    cfg_master #(.BIT_CLKS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .TX_C  (tx),
        .RX_C  (rx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int pulse_at = 0;
    int cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.rsp_rdy === 1'b1) begin
            pulses++;
            pulse_at = cyc;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [23:0] d, input int b);
        logic [7:0] by;
        int p;
        by = d[23 - 8 * (b / 10) -: 8];
        p = b % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return by[p - 1];
    endfunction

    task automatic start_frame(input logic [23:0] d);
        chk("tx_idle_before", 32'(tx), 32'd1);
        bus.cmd_data = d;
        bus.snd_frm = 1'b1;
        tick();
        bus.snd_frm = 1'b0;
        chk("tx_start_next_cycle", 32'(tx), 32'd0);
    endtask

    task automatic run_frame(input logic [23:0] d, input bit inject);
        for (int c = 0; c < 480; c++) begin
            if (inject && c == 100) begin
                bus.cmd_data = 24'hFFFFFF;
                bus.snd_frm = 1'b1;
            end else begin
                bus.snd_frm = 1'b0;
            end
            if (c % 16 == 8)
                chk($sformatf("tx_bit%0d", c / 16), 32'(tx),
                    32'(exp_bit(d, c / 16)));
            tick();
        end
        bus.snd_frm = 1'b0;
        chk("tx_end_idle", 32'(tx), 32'd1);
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) tick();
        end
        rx = stop;
        repeat (16) tick();
        rx = 1'b1;
    endtask

    task automatic quiet(input int n, input string tag);
        int lows;
        lows = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        chk(tag, 32'(lows), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int s;
        bus.cmd_data = '0;
        bus.snd_frm = 1'b0;
        repeat (3) tick();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_resp", 32'(bus.resp), 32'h0000);
        chk("rst_rdy", 32'(bus.rsp_rdy), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        start_frame(24'h031234);
        run_frame(24'h031234, 1'b1);
        start_frame(24'hA55A0F);
        run_frame(24'hA55A0F, 1'b0);
        quiet(40, "tx_quiet_after");

        p0 = pulses;
        rx_byte(8'h0A, 1'b1);
        chk("rx_half_no_rdy", 32'(pulses - p0), 32'd0);
        chk("rx_half_resp", 32'(bus.resp), 32'h0000);
        s = cyc;
        rx_byte(8'h5A, 1'b1);
        chk("rx_word_pulses", 32'(pulses - p0), 32'd1);
        chk("rx_word_resp", 32'(bus.resp), 32'h0A5A);
        chk("rx_rdy_cycle", 32'(pulse_at - s), 32'd153);

        p0 = pulses;
        rx_byte(8'h11, 1'b1);
        rx_byte(8'h05, 1'b0);
        repeat (20) tick();
        rx_byte(8'h05, 1'b1);
        rx_byte(8'hA5, 1'b1);
        chk("frm_err_pulses", 32'(pulses - p0), 32'd1);
        chk("frm_err_resp", 32'(bus.resp), 32'h05A5);

        p0 = pulses;
        rx = 1'b0;
        repeat (8) tick();
        rx = 1'b1;
        repeat (200) tick();
        chk("glitch_no_rdy", 32'(pulses - p0), 32'd0);
        chk("glitch_resp", 32'(bus.resp), 32'h05A5);
        rx_byte(8'h12, 1'b1);
        rx_byte(8'h34, 1'b1);
        chk("post_glitch_resp", 32'(bus.resp), 32'h1234);
        chk("post_glitch_pulses", 32'(pulses - p0), 32'd1);

        rx_byte(8'h77, 1'b1);
        start_frame(24'h5A0001);
        p0 = pulses;
        rx_byte(8'h56, 1'b1);
        rx_byte(8'h78, 1'b1);
        chk("snd_clears_half_pulses", 32'(pulses - p0), 32'd1);
        chk("snd_clears_half_resp", 32'(bus.resp), 32'h5678);
        repeat (200) tick();
        chk("tx_done_after_overlap", 32'(tx), 32'd1);

        start_frame(24'hC3C3C3);
        repeat (100) tick();
        chk("pre_rst_tx_low", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_resp", 32'(bus.resp), 32'h0000);
        chk("async_rst_rdy", 32'(bus.rsp_rdy), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        quiet(50, "tx_quiet_post_rst");
        start_frame(24'h031234);
        run_frame(24'h031234, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
